// File: rtl/seq_detector_if.sv
// Serial-bit detector bus: control/data in (clr, en, din), status out (z, match_cnt, fill).
// The master drives the serial stream; the slave is the detector.
interface seq_detector_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    localparam int FW = $clog2(PAT_W + 1);

    logic             clr;
    logic             en;
    logic             din;
    logic             z;
    logic [CNT_W-1:0] match_cnt;
    logic [FW-1:0]    fill;

    modport master (
        output clr, en, din,
        input  z, match_cnt, fill
    );

    modport slave (
        input  clr, en, din,
        output z, match_cnt, fill
    );
endinterface

// File: rtl/seq_detector.sv
// Serial pattern detector with FILLING/ARMED FSM, overlapping or non-overlapping matching.
// Define SEQ_DETECTOR_CNT_EN to build the saturating match counter; otherwise match_cnt is tied to 0.
module seq_detector #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter int               OVERLAP = 1,
    parameter int               CNT_W   = 8
) (
    input  logic         clk,
    input  logic         rst,
    seq_detector_if.slave bus
);
    localparam int             FW      = $clog2(PAT_W + 1);
    localparam logic [FW-1:0]  FULL    = FW'(PAT_W);
    localparam logic [FW-1:0]  ARM_LVL = FW'(PAT_W - 1);

    typedef enum logic {
        FILLING = 1'b0,
        ARMED   = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [PAT_W-1:0] window_q, window_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic             z_q, z_d;
    logic [PAT_W-1:0] shifted;
    logic             hit;

    assign shifted = {window_q[PAT_W-2:0], bus.din};
    // The fill qualifier keeps zeroed or stale window bits from ever producing a match.
    assign hit     = bus.en && (fill_q >= ARM_LVL) && (shifted == PATTERN);

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        window_d = window_q;
        fill_d   = fill_q;
        z_d      = 1'b0;

        if (bus.clr) begin
            state_d  = FILLING;
            window_d = '0;
            fill_d   = '0;
        end else if (bus.en) begin
            window_d = shifted;
            fill_d   = (fill_q == FULL) ? fill_q : fill_q + 1'b1;
            z_d      = hit;
            if (hit && OVERLAP == 0) begin
                window_d = '0;
                fill_d   = '0;
            end

            unique case (state_q)
                FILLING: if (fill_d == FULL) state_d = ARMED;
                ARMED:   if (hit && OVERLAP == 0) state_d = FILLING;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= FILLING;
            window_q <= '0;
            fill_q   <= '0;
            z_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            window_q <= window_d;
            fill_q   <= fill_d;
            z_q      <= z_d;
        end
    end

    assign bus.z    = z_q;
    assign bus.fill = fill_q;

`ifdef SEQ_DETECTOR_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (bus.clr) begin
            cnt_q <= '0;
        end else if (hit && cnt_q != {CNT_W{1'b1}}) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.match_cnt = cnt_q;
`else
    assign bus.match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detector.sv
// Directed bench for seq_detector: overlapping, non-overlapping and narrow-counter instances
// share one stream; counter expectations follow SEQ_DETECTOR_CNT_EN.
module tb_seq_detector;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    seq_detector_if #(.PAT_W(4), .CNT_W(8)) bus_ov  ();
    seq_detector_if #(.PAT_W(4), .CNT_W(8)) bus_no  ();
    seq_detector_if #(.PAT_W(4), .CNT_W(2)) bus_sat ();

    seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(8)) dut_ov (
        .clk(clk), .rst(rst), .bus(bus_ov)
    );
    seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(8)) dut_no (
        .clk(clk), .rst(rst), .bus(bus_no)
    );
    seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .bus(bus_sat)
    );

    function automatic int exp_cnt(input int n, input int max);
`ifdef SEQ_DETECTOR_CNT_EN
        return (n > max) ? max : n;
`else
        return 0;
`endif
    endfunction

    task automatic drive(input logic c, input logic e, input logic d);
        bus_ov.clr  = c; bus_ov.en  = e; bus_ov.din  = d;
        bus_no.clr  = c; bus_no.en  = e; bus_no.din  = d;
        bus_sat.clr = c; bus_sat.en = e; bus_sat.din = d;
    endtask

    task automatic step(input logic c, input logic e, input logic d);
        drive(c, e, d);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        drive(1'b0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        if (bus_ov.z !== 1'b0 || bus_ov.fill !== 3'd0 || int'(bus_ov.match_cnt) !== 0) begin
            mismatched++;
            $display("FAIL reset_ov: z=%b fill=%0d cnt=%0d, want 0/0/0", bus_ov.z, bus_ov.fill, bus_ov.match_cnt);
        end
        compared++;
        if (bus_no.z !== 1'b0 || bus_no.fill !== 3'd0 || bus_sat.fill !== 3'd0) begin
            mismatched++;
            $display("FAIL reset_others: z_no=%b fill_no=%0d fill_sat=%0d, want 0/0/0",
                     bus_no.z, bus_no.fill, bus_sat.fill);
        end
        compared++;
        drive(1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        step(1'b0, 1'b1, 1'b1);
        if (bus_ov.fill !== 3'd1) begin
            mismatched++;
            $display("FAIL first_sample: fill=%0d, want 1", bus_ov.fill);
        end
        compared++;
    endtask

    task automatic test_clear;
        step(1'b1, 1'b1, 1'b1);
        if (bus_ov.fill !== 3'd0 || bus_ov.z !== 1'b0) begin
            mismatched++;
            $display("FAIL clr_priority: fill=%0d z=%b, want 0/0", bus_ov.fill, bus_ov.z);
        end
        compared++;
    endtask

    task automatic test_overlap;
        logic [6:0] bits;
        logic [6:0] zexp;
        bits = 7'b1011011;
        zexp = 7'b0001001;
        test_clear();
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, bits[6-i]);
            if (bus_ov.z !== zexp[6-i]) begin
                mismatched++;
                $display("FAIL overlap_z bit%0d: z=%b, want %b", i + 1, bus_ov.z, zexp[6-i]);
            end
            compared++;
        end
        if (int'(bus_ov.match_cnt) !== exp_cnt(2, 255) || bus_ov.fill !== 3'd4) begin
            mismatched++;
            $display("FAIL overlap_end: cnt=%0d fill=%0d, want %0d/4",
                     bus_ov.match_cnt, bus_ov.fill, exp_cnt(2, 255));
        end
        compared++;
    endtask

    task automatic test_non_overlap;
        logic [6:0] bits;
        logic [6:0] zexp;
        bits = 7'b1011011;
        zexp = 7'b0001000;
        test_clear();
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, bits[6-i]);
            if (bus_no.z !== zexp[6-i]) begin
                mismatched++;
                $display("FAIL nonoverlap_z bit%0d: z=%b, want %b", i + 1, bus_no.z, zexp[6-i]);
            end
            compared++;
        end
        if (int'(bus_no.match_cnt) !== exp_cnt(1, 255) || bus_no.fill !== 3'd3) begin
            mismatched++;
            $display("FAIL nonoverlap_end: cnt=%0d fill=%0d, want %0d/3",
                     bus_no.match_cnt, bus_no.fill, exp_cnt(1, 255));
        end
        compared++;
    endtask

    task automatic test_gap;
        test_clear();
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1);
            if (bus_ov.z !== 1'b0 || bus_ov.fill !== 3'd3) begin
                mismatched++;
                $display("FAIL gap_hold cyc%0d: z=%b fill=%0d, want 0/3", i, bus_ov.z, bus_ov.fill);
            end
            compared++;
        end
        step(1'b0, 1'b1, 1'b1);
        if (bus_ov.z !== 1'b1 || bus_ov.fill !== 3'd4) begin
            mismatched++;
            $display("FAIL gap_match: z=%b fill=%0d, want 1/4", bus_ov.z, bus_ov.fill);
        end
        compared++;
        step(1'b0, 1'b0, 1'b1);
        if (bus_ov.z !== 1'b0) begin
            mismatched++;
            $display("FAIL gap_pulse_width: z=%b, want 0", bus_ov.z);
        end
        compared++;
    endtask

    task automatic test_reset_mid;
        test_clear();
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        if (bus_ov.fill !== 3'd0 || bus_no.fill !== 3'd0) begin
            mismatched++;
            $display("FAIL async_reset: fill_ov=%0d fill_no=%0d, want 0/0", bus_ov.fill, bus_no.fill);
        end
        compared++;
        #1;
        rst = 1'b0;
        step(1'b0, 1'b1, 1'b1);
        if (bus_ov.z !== 1'b0 || bus_ov.fill !== 3'd1) begin
            mismatched++;
            $display("FAIL reset_mid: z=%b fill=%0d, want 0/1", bus_ov.z, bus_ov.fill);
        end
        compared++;
    endtask

    task automatic test_saturation;
        logic [3:0] pat;
        pat = 4'b1011;
        test_clear();
        for (int r = 1; r <= 5; r++) begin
            for (int i = 0; i < 4; i++) begin
                step(1'b0, 1'b1, pat[3-i]);
            end
            if (bus_sat.z !== 1'b1 || int'(bus_sat.match_cnt) !== exp_cnt(r, 3)) begin
                mismatched++;
                $display("FAIL sat_rep%0d: z=%b cnt=%0d, want 1/%0d", r, bus_sat.z, bus_sat.match_cnt, exp_cnt(r, 3));
            end
            compared++;
        end
        step(1'b1, 1'b0, 1'b0);
        if (int'(bus_sat.match_cnt) !== 0 || bus_sat.fill !== 3'd0 || bus_sat.z !== 1'b0) begin
            mismatched++;
            $display("FAIL sat_clr: cnt=%0d fill=%0d z=%b, want 0/0/0", bus_sat.match_cnt, bus_sat.fill, bus_sat.z);
        end
        compared++;
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0);
        test_reset();
        test_overlap();
        test_non_overlap();
        test_gap();
        test_reset_mid();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/seq_detector.md
SEQ_DETECTOR -- requirements
Module: seq_detector

Interface
REQ-001 Parameter PAT_W, default 4: pattern length in bits, legal range 2..16.
REQ-002 Parameter PATTERN, default 4'b1011: the PAT_W-bit target sequence; bit PAT_W-1 is the oldest bit, bit 0 the newest.
REQ-003 Parameter OVERLAP, default 1: 1 = overlapping detection, 0 = non-overlapping detection.
REQ-004 Parameter CNT_W, default 8: width of the match counter.
REQ-005 Localparam FW = clog2(PAT_W+1): width of the fill-level output.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 clr  input  1  synchronous clear of all detection state.
REQ-009 en  input  1  serial-bit valid; din is sampled only when en=1.
REQ-010 din  input  1  serial data bit.
REQ-011 z  output  1  registered one-cycle match pulse.
REQ-012 match_cnt  output  CNT_W  number of matches since reset or clr.
REQ-013 fill  output  FW  number of valid bits currently held in the window (0..PAT_W).

Function
REQ-014 The block SHALL hold a PAT_W-bit shift window; on an edge with en=1 and clr=0: window <= {window[PAT_W-2:0], din}.
REQ-015 On that edge, fill SHALL become min(fill+1, PAT_W).
REQ-016 hit SHALL be defined as: (fill >= PAT_W-1) AND ({window[PAT_W-2:0], din} == PATTERN).
REQ-017 On that edge, z SHALL be set to hit, giving a latency of 1 cycle from the edge that samples the completing bit.
REQ-018 With en=0 and clr=0, window, fill and match_cnt SHALL hold, and z SHALL be 0 on the next cycle.
REQ-019 z SHALL never be high for two consecutive cycles unless en=1 and hit=1 on both edges.
REQ-020 With OVERLAP=1, a hit SHALL leave the window and fill updated as in REQ-014/REQ-015, so the bits of one match can form part of the next match.
REQ-021 With OVERLAP=0, a hit SHALL set fill to 0 and the window to 0, so that no bit takes part in two matches.
REQ-022 On each edge with hit=1, match_cnt SHALL increment by 1 and saturate at 2^CNT_W-1, with no wrap.
REQ-023 clr=1 SHALL, on the next edge, zero window, fill, z and match_cnt; clr SHALL take priority over en.
REQ-024 While fill < PAT_W-1, z SHALL remain 0 regardless of the window contents, so stale or zeroed bits never match.
REQ-025 The block SHALL behave as an explicit state machine with states FILLING (fill < PAT_W) and ARMED (fill = PAT_W).
REQ-026 State transitions: FILLING->ARMED when fill reaches PAT_W; ARMED->FILLING on clr, or on a hit when OVERLAP=0.

Reset
REQ-027 Assertion of rst SHALL immediately and asynchronously set window=0, fill=0, z=0 and match_cnt=0.
REQ-028 Assertion of rst mid-sequence SHALL discard partial progress, and detection SHALL restart from an empty window.
REQ-029 The first din sample after rst deasserts SHALL be taken on the first rising edge at which en=1.

Configuration
REQ-030 Macro SEQ_DETECTOR_CNT_EN, when defined, SHALL compile in the match_cnt register and its saturating increment logic.
REQ-031 When SEQ_DETECTOR_CNT_EN is undefined, match_cnt SHALL be tied to 0, no counter flops SHALL exist, and z and fill behaviour SHALL be unchanged.

Verification
All scenarios use PAT_W=4, PATTERN=4'b1011, CNT_W=8 and SEQ_DETECTOR_CNT_EN defined, unless stated otherwise.
REQ-032 OVERLAP=1, din stream 1,0,1,1,0,1,1 with en=1 -> z pulses after the 4th and 7th bits; match_cnt=2.
REQ-033 OVERLAP=0, same stream -> z pulses only after the 4th bit; match_cnt=1; fill=3 at the end.
REQ-034 Stream 1,0,1 with en=1, then en=0 for 3 cycles, then din=1 with en=1 -> z stays 0 during the gap; z pulses once after the final bit; fill holds at 3 during the gap.
REQ-035 rst pulsed after bits 1,0,1, then bit 1 -> no z pulse; fill=1 after the bit.
REQ-036 CNT_W=2, OVERLAP=1, stream 1,0,1,1 repeated 5 times -> match_cnt saturates at 3; clr then gives match_cnt=0, fill=0, z=0 on the next cycle.
REQ-037 SEQ_DETECTOR_CNT_EN undefined, stimulus of REQ-032 -> identical z pulses; match_cnt=0 throughout.
